// File: rtl/router_pkg.sv
// router_pkg -- shared definitions for the router packet FIFO.
//   DATA_W_DEF     : default data word width (8)
//   HDR_BIT        : index of the header tag bit inside a stored word
//   tagged_word_t  : one stored FIFO entry, {hdr, data}
//   hdr_len()      : payload length field of a header byte, word[DATA_W-1:2]
package router_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int HDR_BIT    = DATA_W_DEF;

  typedef struct packed {
    logic                  hdr;
    logic [DATA_W_DEF-1:0] data;
  } tagged_word_t;

  function automatic logic [DATA_W_DEF-3:0] hdr_len(input logic [DATA_W_DEF-1:0] word);
    return word[DATA_W_DEF-1:2];
  endfunction
endpackage

// File: rtl/router_pkt_fifo_if.sv
// router_pkt_fifo_if -- write/read handshake and status bundle of the packet FIFO.
//   master : router side (drives write_enb, read_enb, lfd_state, data_in)
//   slave  : FIFO side (drives data_out, data_valid, flags, occupancy, pkt_remain, pkt_end)
// Optional feature macro: ROUTER_FIFO_ERR_EN adds sticky ovf_err / udf_err.
interface router_pkt_fifo_if
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              write_enb;
  logic              read_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [AW:0]       occupancy;
  logic [DATA_W-2:0] pkt_remain;
  logic              pkt_end;
`ifdef ROUTER_FIFO_ERR_EN
  logic              ovf_err;
  logic              udf_err;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, data_valid, full, empty, almost_full, occupancy,
           pkt_remain, pkt_end, ovf_err, udf_err
  );
  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, data_valid, full, empty, almost_full, occupancy,
           pkt_remain, pkt_end, ovf_err, udf_err
  );
`else
  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, data_valid, full, empty, almost_full, occupancy,
           pkt_remain, pkt_end
  );
  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, data_valid, full, empty, almost_full, occupancy,
           pkt_remain, pkt_end
  );
`endif
endinterface

// File: rtl/router_fifo_ptr.sv
// router_fifo_ptr -- FIFO pointer with wrap bit (AW+1 bits, wraps modulo 2*DEPTH).
//   clock, resetn : clock and asynchronous active-low reset
//   clr_i         : synchronous clear, takes priority over inc_i
//   inc_i         : advance pointer by one
//   ptr_o         : current pointer, MSB is the wrap bit
module router_fifo_ptr #(
  parameter int AW = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [AW:0] ptr_o
);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + PTR_ONE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo -- per-destination packet FIFO between the router register stage and
// one output port. Stores {header tag, data} words, tracks bytes left in the packet
// being read, and reports occupancy / almost-full.
//   clock      : rising-edge clock
//   resetn     : asynchronous active-low reset
//   soft_reset : synchronous flush, overrides reads and writes in its cycle
//   bus        : router_pkt_fifo_if.slave (write/read handshake, data, status)
// Optional feature macro: ROUTER_FIFO_ERR_EN -- sticky ovf_err (write while full) and
// udf_err (read while empty, or an untagged byte outside any packet).
// The stored word type comes from router_pkg, so DATA_W must equal DATA_W_DEF.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2
) (
  input logic               clock,
  input logic               resetn,
  input logic               soft_reset,
  router_pkt_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_W-2:0] REM_ONE = 1;
  localparam logic [AW:0]       AF_LVL  = (AW+1)'(AF_THRESH);

  logic [AW:0]  wr_ptr, rd_ptr, occ;
  logic         empty, full, wr_acc, rd_acc;
  tagged_word_t mem_q [DEPTH];
  tagged_word_t rd_word;

  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic [DATA_W-2:0] pkt_remain_q, pkt_remain_d;
  logic              pkt_end_q, pkt_end_d;
  logic              stray;

  // Status decoded from registered pointers only.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign occ    = wr_ptr - rd_ptr;
  assign wr_acc = bus.write_enb && !full;
  assign rd_acc = bus.read_enb && !empty;

  router_fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clock(clock), .resetn(resetn), .clr_i(soft_reset), .inc_i(wr_acc), .ptr_o(wr_ptr)
  );
  router_fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clock(clock), .resetn(resetn), .clr_i(soft_reset), .inc_i(rd_acc), .ptr_o(rd_ptr)
  );

  // Storage is not reset; only pointers define what is valid.
  always_ff @(posedge clock) begin
    if (wr_acc && !soft_reset)
      mem_q[wr_ptr[AW-1:0]] <= '{hdr: bus.lfd_state, data: bus.data_in};
  end

  assign rd_word = mem_q[rd_ptr[AW-1:0]];

  // Packet byte counter: a header loads len+1 (payload plus parity byte).
  always_comb begin
    pkt_remain_d = pkt_remain_q;
    pkt_end_d    = 1'b0;
    stray        = 1'b0;
    if (rd_acc) begin
      if (rd_word.hdr) begin
        pkt_remain_d = {1'b0, hdr_len(rd_word.data)} + REM_ONE;
      end else if (pkt_remain_q != '0) begin
        pkt_remain_d = pkt_remain_q - REM_ONE;
        pkt_end_d    = (pkt_remain_q == REM_ONE);
      end else begin
        stray = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pkt_remain_q <= '0;
      pkt_end_q    <= 1'b0;
    end else if (soft_reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pkt_remain_q <= '0;
      pkt_end_q    <= 1'b0;
    end else begin
      data_valid_q <= rd_acc;
      if (rd_acc) data_out_q <= rd_word.data;
      pkt_remain_q <= pkt_remain_d;
      pkt_end_q    <= pkt_end_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (occ >= AF_LVL);
  assign bus.occupancy   = occ;
  assign bus.pkt_remain  = pkt_remain_q;
  assign bus.pkt_end     = pkt_end_q;

`ifdef ROUTER_FIFO_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (soft_reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.write_enb && full)                  ovf_q <= 1'b1;
      if ((bus.read_enb && empty) || stray)       udf_q <= 1'b1;
    end
  end

  assign bus.ovf_err = ovf_q;
  assign bus.udf_err = udf_q;
`else
  logic unused_stray;
  assign unused_stray = stray;
`endif
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo -- randomized and directed stimulus for router_pkt_fifo, checked
// against a queue-based reference model; read data is checked by a separate monitor
// popping a scoreboard of expected words.
module tb_router_pkt_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic soft_reset = 1'b0;

  always #5 clock = ~clock;

  router_pkt_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  router_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(DEPTH-2)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [8:0] mq[$];       // stored {hdr, data}
  logic [7:0] sb[$];       // expected read data, popped by monitor
  int  remain = 0;
  bit  exp_end = 0, exp_valid = 0, ovf = 0, udf = 0;
  int  end_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    remain = 0; exp_end = 0; exp_valid = 0; ovf = 0; udf = 0;
  endtask

  task automatic check_flags();
    check("occupancy", 32'(bus.occupancy), 32'(mq.size()));
    check("empty", 32'(bus.empty), 32'(mq.size() == 0));
    check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    check("almost_full", 32'(bus.almost_full), 32'(mq.size() >= DEPTH-2));
    check("pkt_remain", 32'(bus.pkt_remain), 32'(remain));
    check("pkt_end", 32'(bus.pkt_end), 32'(exp_end));
    check("data_valid", 32'(bus.data_valid), 32'(exp_valid));
`ifdef ROUTER_FIFO_ERR_EN
    check("ovf_err", 32'(bus.ovf_err), 32'(ovf));
    check("udf_err", 32'(bus.udf_err), 32'(udf));
`endif
  endtask

  // One clock: drive at negedge, predict, then check after the posedge.
  task automatic step(input bit we, input bit re, input bit lfd, input logic [7:0] din,
                      input bit srst);
    logic [8:0] w;
    bit was_full, was_empty, stray;
    bus.write_enb = we; bus.read_enb = re; bus.lfd_state = lfd; bus.data_in = din;
    soft_reset = srst;
    if (srst) begin
      model_reset();
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      stray = 0;
      exp_end = 0;
      exp_valid = 0;
      if (re && !was_empty) begin
        w = mq.pop_front();
        sb.push_back(w[7:0]);
        exp_valid = 1;
        if (w[8]) remain = int'(w[7:2]) + 1;
        else if (remain != 0) begin
          remain = remain - 1;
          exp_end = (remain == 0);
        end else stray = 1;
      end
      if (we && !was_full) mq.push_back({lfd, din});
      if (we && was_full) ovf = 1;
      if ((re && was_empty) || stray) udf = 1;
    end
    @(posedge clock);
    @(negedge clock);
    bus.write_enb = 0; bus.read_enb = 0; bus.lfd_state = 0; soft_reset = 0;
    if (bus.pkt_end) end_count++;
    check_flags();
  endtask

  // Monitor: compares each presented read word against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (resetn && bus.data_valid) begin
        if (sb.size() == 0) check("unexpected_valid", 32'(1), 32'(0));
        else begin
          e = sb.pop_front();
          check("data_out", 32'(bus.data_out), 32'(e));
        end
      end
    end
  end

  initial begin
    bus.write_enb = 0; bus.read_enb = 0; bus.lfd_state = 0; bus.data_in = '0;
    // 1: power-on reset, then async reset mid-burst
    repeat (2) @(negedge clock);
    check("rst_empty", 32'(bus.empty), 32'(1));
    check("rst_data_out", 32'(bus.data_out), 32'(0));
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) step(1, i > 2, 0, 8'(i + 8'h30), 0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    sb.delete();
    check("arst_empty", 32'(bus.empty), 32'(1));
    check("arst_occ", 32'(bus.occupancy), 32'(0));
    check("arst_valid", 32'(bus.data_valid), 32'(0));
    check("arst_remain", 32'(bus.pkt_remain), 32'(0));
    @(negedge clock);
    resetn = 1'b1;
    check_flags();

    // 2: fill; 17th write dropped
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, 8'($urandom), 0);
    check("fill_occ16", 32'(bus.occupancy), 32'(16));
    check("fill_full", 32'(bus.full), 32'(1));

    // 4: full + write&read -> read proceeds, write dropped
    step(1, 1, 0, 8'hEE, 0);
    check("full_rw_occ", 32'(bus.occupancy), 32'(15));
    while (mq.size() > 8) step(0, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h5A, 0);
    check("half_rw_occ", 32'(bus.occupancy), 32'(8));

    // 3: packet 8'h0D (len=3) + 3 payload + parity
    step(0, 0, 0, 8'h00, 1);
    step(1, 0, 1, 8'h0D, 0);
    step(1, 0, 0, 8'hA1, 0);
    step(1, 0, 0, 8'hA2, 0);
    step(1, 0, 0, 8'hA3, 0);
    step(1, 0, 0, 8'h77, 0);
    end_count = 0;
    step(0, 1, 0, 8'h00, 0);
    check("hdr_remain4", 32'(bus.pkt_remain), 32'(4));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 0);
    check("pkt_end_once", 32'(end_count), 32'(1));
    step(0, 0, 0, 8'h00, 0);
    check("pkt_end_after", 32'(end_count), 32'(1));

    // 5: wrap with 40 write/read pairs
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'($urandom), 0);
    for (int i = 0; i < 40; i++) step(1, 1, 0, 8'($urandom), 0);

    // random traffic, headers and occasional flush
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 49) == 0));

    // 6: soft_reset with 5 words held
    step(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(1, 0, i == 0, 8'(8'h10 + i), 0);
    step(0, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h99, 1);
    check("srst_empty", 32'(bus.empty), 32'(1));
    check("srst_remain", 32'(bus.pkt_remain), 32'(0));
`ifdef ROUTER_FIFO_ERR_EN
    step(0, 1, 0, 8'h00, 0);
    check("udf_set", 32'(bus.udf_err), 32'(1));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'($urandom), 0);
    check("udf_sticky", 32'(bus.udf_err), 32'(1));
    step(0, 0, 0, 8'h00, 1);
    check("udf_clear", 32'(bus.udf_err), 32'(0));
`endif
    step(0, 0, 0, 8'h00, 0);
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
